// File: rtl/simple_branch_wr.sv
// ---------------------------------------------------------------------------
// simple_branch_wr
//
// Registered two-way dataflow branch. Each transfer consumes one data token
// together with one steering token and routes the payload to either the left
// or the right output stream. Each side has its own 2-entry buffer. The
// back-stops depend only on registered occupancy and the incoming token pair,
// so there is never a combinational path from a downstream stop to an
// upstream stop.
//
// Handshake: a token is offered when its valid bit (MSB) is 1. A producer's
// token is consumed at a rising edge when its back-stop is 0 at that edge.
// A consumer takes the head token at a rising edge when the valid bit is 1
// and its down_stop is 0. While down_stop is 1 the output token is held.
//
// Ports:
//   clk                     clock, all state updates on the rising edge
//   reset                   asynchronous active-high reset
//   in_data[F:0]            input data token, bit F = valid
//   in_back_stop            1 = in_data not consumed this cycle
//   choose_right[1:0]       steering token, bit 1 = valid, bit 0 = 1:right
//   choose_right_back_stop  1 = choose_right not consumed this cycle
//   left_data[F:0]          head of the left buffer, bit F = valid
//   left_down_stop          1 = left consumer stalls
//   right_data[F:0]         head of the right buffer, bit F = valid
//   right_down_stop         1 = right consumer stalls
// ---------------------------------------------------------------------------
module simple_branch_wr #(
    parameter int F = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [F:0]   in_data,
    output logic         in_back_stop,
    input  logic [1:0]   choose_right,
    output logic         choose_right_back_stop,
    output logic [F:0]   left_data,
    input  logic         left_down_stop,
    output logic [F:0]   right_data,
    input  logic         right_down_stop
);

    // Buffer state per side: entry0 is the head, entry1 the one behind it.
    logic [1:0]   r_occ_l;
    logic [F-1:0] r_e0_l;
    logic [F-1:0] r_e1_l;
    logic [1:0]   r_occ_r;
    logic [F-1:0] r_e0_r;
    logic [F-1:0] r_e1_r;

    logic [1:0]   w_occ_l_nxt;
    logic [F-1:0] w_e0_l_nxt;
    logic [F-1:0] w_e1_l_nxt;
    logic [1:0]   w_occ_r_nxt;
    logic [F-1:0] w_e0_r_nxt;
    logic [F-1:0] w_e1_r_nxt;

    logic         w_full_l;
    logic         w_full_r;
    logic         w_sel_full;
    logic         w_fire;
    logic         w_push_l;
    logic         w_push_r;
    logic         w_pop_l;
    logic         w_pop_r;
    logic [F-1:0] w_payload;

    assign w_payload = in_data[F-1:0];

    // Fullness comes from registered occupancy only: a pop in the same cycle
    // does not reopen the slot, which keeps down_stop out of the back-stop.
    assign w_full_l   = (r_occ_l == 2'd2);
    assign w_full_r   = (r_occ_r == 2'd2);
    assign w_sel_full = choose_right[0] ? w_full_r : w_full_l;

    // Both tokens must be valid; the direction bit is only meaningful then.
    assign w_fire   = in_data[F] & choose_right[1] & ~w_sel_full;
    assign w_push_l = w_fire & ~choose_right[0];
    assign w_push_r = w_fire &  choose_right[0];

    assign w_pop_l = (r_occ_l != 2'd0) & ~left_down_stop;
    assign w_pop_r = (r_occ_r != 2'd0) & ~right_down_stop;

    // Nothing is accepted while reset is held, even though the buffers are
    // empty then.
    assign in_back_stop           = ~w_fire | reset;
    assign choose_right_back_stop = ~w_fire | reset;

    // Left buffer next state.
    always_comb begin
        w_occ_l_nxt = r_occ_l;
        w_e0_l_nxt  = r_e0_l;
        w_e1_l_nxt  = r_e1_l;
        case ({w_push_l, w_pop_l})
            2'b10: begin
                if (r_occ_l == 2'd0) begin
                    w_e0_l_nxt  = w_payload;
                    w_occ_l_nxt = 2'd1;
                end else begin
                    w_e1_l_nxt  = w_payload;
                    w_occ_l_nxt = 2'd2;
                end
            end
            2'b01: begin
                // Shift up; vacated entries are cleared so an empty side
                // presents an all-zero token.
                w_e0_l_nxt  = r_e1_l;
                w_e1_l_nxt  = '0;
                w_occ_l_nxt = r_occ_l - 2'd1;
            end
            2'b11: begin
                // Only reachable with occupancy 1: new item replaces the head.
                w_e0_l_nxt = w_payload;
            end
            default: begin
            end
        endcase
    end

    // Right buffer next state.
    always_comb begin
        w_occ_r_nxt = r_occ_r;
        w_e0_r_nxt  = r_e0_r;
        w_e1_r_nxt  = r_e1_r;
        case ({w_push_r, w_pop_r})
            2'b10: begin
                if (r_occ_r == 2'd0) begin
                    w_e0_r_nxt  = w_payload;
                    w_occ_r_nxt = 2'd1;
                end else begin
                    w_e1_r_nxt  = w_payload;
                    w_occ_r_nxt = 2'd2;
                end
            end
            2'b01: begin
                w_e0_r_nxt  = r_e1_r;
                w_e1_r_nxt  = '0;
                w_occ_r_nxt = r_occ_r - 2'd1;
            end
            2'b11: begin
                w_e0_r_nxt = w_payload;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_occ_l <= 2'd0;
            r_e0_l  <= '0;
            r_e1_l  <= '0;
            r_occ_r <= 2'd0;
            r_e0_r  <= '0;
            r_e1_r  <= '0;
        end else begin
            r_occ_l <= w_occ_l_nxt;
            r_e0_l  <= w_e0_l_nxt;
            r_e1_l  <= w_e1_l_nxt;
            r_occ_r <= w_occ_r_nxt;
            r_e0_r  <= w_e0_r_nxt;
            r_e1_r  <= w_e1_r_nxt;
        end
    end

    // The payload is gated as well so an empty side is all zeros even if a
    // stale value were ever left in entry0.
    assign left_data  = {(r_occ_l != 2'd0), r_e0_l & {F{r_occ_l != 2'd0}}};
    assign right_data = {(r_occ_r != 2'd0), r_e0_r & {F{r_occ_r != 2'd0}}};

endmodule

// File: tb/tb_simple_branch_wr.sv
module tb_simple_branch_wr;

  localparam int F = 8;

  // clock / reset
  logic         clk;
  logic         reset;
  logic [F:0]   in_data;
  logic         in_back_stop;
  logic [1:0]   choose_right;
  logic         choose_right_back_stop;
  logic [F:0]   left_data;
  logic         left_down_stop;
  logic [F:0]   right_data;
  logic         right_down_stop;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  simple_branch_wr #(.F(F)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .in_data                (in_data),
    .in_back_stop           (in_back_stop),
    .choose_right           (choose_right),
    .choose_right_back_stop (choose_right_back_stop),
    .left_data              (left_data),
    .left_down_stop         (left_down_stop),
    .right_data             (right_data),
    .right_down_stop        (right_down_stop)
  );

  // scoreboard
  logic [F-1:0] exp_l[$];
  logic [F-1:0] exp_r[$];
  int           m_occ_l;
  int           m_occ_r;
  logic         last_fire;
  int           checks;
  int           errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic iv, input logic [F-1:0] pl, input logic cv, input logic cd);
    in_data      = {iv, pl};
    choose_right = {cv, cd};
  endtask

  task automatic stops(input logic ls, input logic rs);
    left_down_stop  = ls;
    right_down_stop = rs;
  endtask

  task automatic model_reset();
    exp_l.delete();
    exp_r.delete();
    m_occ_l = 0;
    m_occ_r = 0;
  endtask

  // One clock cycle: inputs were set after the falling edge; check the
  // outputs against the model, account for pops/pushes at the coming rising
  // edge, then advance to the next falling edge.
  task automatic cycle();
    logic fire;
    logic [F-1:0] head;
    #1;
    fire = in_data[F] && choose_right[1] &&
           ((choose_right[0] ? m_occ_r : m_occ_l) != 2);
    last_fire = fire;
    chk("in_back_stop", in_back_stop, !fire);
    chk("cr_back_stop", choose_right_back_stop, !fire);
    chk("left_valid", left_data[F], m_occ_l != 0);
    chk("right_valid", right_data[F], m_occ_r != 0);
    if (m_occ_l == 0) begin
      chk("left_zero", left_data, 0);
    end else begin
      head = exp_l[0];
      chk("left_head", left_data, {1'b1, head});
      if (!left_down_stop) begin
        void'(exp_l.pop_front());
        m_occ_l--;
      end
    end
    if (m_occ_r == 0) begin
      chk("right_zero", right_data, 0);
    end else begin
      head = exp_r[0];
      chk("right_head", right_data, {1'b1, head});
      if (!right_down_stop) begin
        void'(exp_r.pop_front());
        m_occ_r--;
      end
    end
    if (fire) begin
      if (choose_right[0]) begin
        exp_r.push_back(in_data[F-1:0]);
        m_occ_r++;
      end else begin
        exp_l.push_back(in_data[F-1:0]);
        m_occ_l++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int guard;
    logic [F-1:0] pl;
    logic dir;
    checks = 0;
    errors = 0;
    last_fire = 1'b0;
    model_reset();

    // power-on reset
    reset = 1'b1;
    drive(1'b1, 8'h55, 1'b1, 1'b0);
    stops(1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_in_bs", in_back_stop, 1);
    chk("reset_cr_bs", choose_right_back_stop, 1);
    chk("reset_left", left_data, 0);
    chk("reset_right", right_data, 0);
    reset = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);

    // steer left then right
    drive(1'b1, 8'hA5, 1'b1, 1'b0);
    cycle();
    chk("steer_left_out", left_data, 9'h1A5);
    chk("steer_right_idle", right_data, 0);
    drive(1'b1, 8'h3C, 1'b1, 1'b1);
    cycle();
    chk("steer_right_out", right_data, 9'h13C);
    chk("steer_left_gone", left_data, 0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    cycle();

    // missing steering partner
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    cycle();
    cycle();
    cycle();
    drive(1'b1, 8'h77, 1'b1, 1'b1);
    cycle();
    chk("partner_right_out", right_data, 9'h177);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    cycle();

    // right fill under stall, left still flowing
    stops(1'b0, 1'b1);
    drive(1'b1, 8'h01, 1'b1, 1'b1);
    cycle();
    drive(1'b1, 8'h02, 1'b1, 1'b1);
    cycle();
    drive(1'b1, 8'h03, 1'b1, 1'b1);
    cycle();
    chk("fill_third_stalled", in_back_stop, 1);
    chk("fill_right_held", right_data, 9'h101);
    drive(1'b1, 8'h44, 1'b1, 1'b0);
    cycle();
    chk("fill_left_passes", left_data, 9'h144);
    chk("fill_right_still", right_data, 9'h101);
    // release with a right pair presented while full: pop now, push next edge
    drive(1'b1, 8'h03, 1'b1, 1'b1);
    stops(1'b0, 1'b0);
    cycle();
    chk("fullpop_refused", last_fire, 0);
    chk("release_second", right_data, 9'h102);
    cycle();
    chk("fullpop_accepted", last_fire, 1);
    chk("release_third", right_data, 9'h103);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    cycle();
    chk("release_empty", right_data, 0);

    // reset mid-stream with two items buffered left
    stops(1'b1, 1'b0);
    drive(1'b1, 8'h11, 1'b1, 1'b0);
    cycle();
    drive(1'b1, 8'h22, 1'b1, 1'b0);
    cycle();
    chk("midreset_pre", left_data, 9'h111);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_left", left_data, 0);
    chk("midreset_in_bs", in_back_stop, 1);
    chk("midreset_cr_bs", choose_right_back_stop, 1);
    #1;
    reset = 1'b0;
    model_reset();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    stops(1'b0, 1'b0);
    @(negedge clk);
    cycle();

    // streaming with random stalls
    for (int k = 0; k < 16; k++) begin
      pl  = 8'($urandom_range(0, 255));
      dir = 1'($urandom_range(0, 1));
      guard = 0;
      last_fire = 1'b0;
      while (!last_fire && guard < 200) begin
        drive(($urandom_range(0, 3) != 0), pl, 1'b1, dir);
        stops(($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
        cycle();
        guard++;
      end
      chk("stream_progress", (guard < 200), 1);
    end

    // drain
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    stops(1'b0, 1'b0);
    for (int k = 0; k < 4; k++) cycle();
    chk("drain_left_empty", exp_l.size(), 0);
    chk("drain_right_empty", exp_r.size(), 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
